exponent_job_sequencer: RTL



---
 rtl/exponent_job_sequencer.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/exponent_job_sequencer.sv
// ============================================================================
// Module      : exponent_job_sequencer
// Description : AXI4-Lite master that runs one P = X^A job on the exponent slave
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module exponent_job_sequencer #(
   parameter logic [31:0] BASE_ADDR  = 32'h7c800000,
   parameter int unsigned POLL_LIMIT = 1024,
   parameter int unsigned POLL_GAP   = 4,
   parameter int unsigned RES_W      = 30
) (
   input  logic             M_AXI_ACLK,
   input  logic             M_AXI_ARESET,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [31:0]      job_x,
   input  logic [31:0]      job_a,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic [1:0]       res_err,
   output logic             busy,
   output logic [31:0]      M_AXI_AWADDR,
   output logic             M_AXI_AWVALID,
   input  logic             M_AXI_AWREADY,
   output logic [31:0]      M_AXI_WDATA,
   output logic [3:0]       M_AXI_WSTRB,
   output logic             M_AXI_WVALID,
   input  logic             M_AXI_WREADY,
   input  logic             M_AXI_BVALID,
   output logic             M_AXI_BREADY,
   input  logic [1:0]       M_AXI_BRESP,
   output logic [31:0]      M_AXI_ARADDR,
   output logic             M_AXI_ARVALID,
   input  logic             M_AXI_ARREADY,
   input  logic             M_AXI_RVALID,
   output logic             M_AXI_RREADY,
   input  logic [31:0]      M_AXI_RDATA,
   input  logic [1:0]       M_AXI_RRESP
);

   localparam logic [31:0] c_addr_x     = BASE_ADDR;
   localparam logic [31:0] c_addr_a     = BASE_ADDR + 32'h04;
   localparam logic [31:0] c_addr_start = BASE_ADDR + 32'h08;
   localparam logic [31:0] c_addr_p     = BASE_ADDR + 32'h0C;
   localparam logic [31:0] c_addr_done  = BASE_ADDR + 32'h10;
   localparam logic [15:0] c_limit      = 16'(POLL_LIMIT);
   localparam logic [15:0] c_gap_last   = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

   typedef enum logic [3:0] {
      IDLE, WR_X, WR_A, WR_START, POLL_AR, POLL_R, POLL_WAIT, RD_P_AR, RD_P_R, RESP
   } state_t;

   state_t           r_state, w_state;
   logic [31:0]      r_a, w_a;
   logic [15:0]      r_poll_cnt, w_poll_cnt;
   logic [15:0]      r_gap_cnt, w_gap_cnt;
   logic             w_job_ready, w_res_valid, w_awvalid, w_wvalid, w_bready;
   logic             w_arvalid, w_rready;
   logic [RES_W-1:0] w_res_data;
   logic [1:0]       w_res_err;
   logic [31:0]      w_awaddr, w_wdata, w_araddr;

   // Bits of RDATA above RES_W carry nothing the sequencer needs.
   logic w_unused_rdata;
   assign w_unused_rdata = ^M_AXI_RDATA;

   assign M_AXI_WSTRB = 4'hF;

   always_comb begin
      w_state     = r_state;
      w_a         = r_a;
      w_poll_cnt  = r_poll_cnt;
      w_gap_cnt   = r_gap_cnt;
      w_job_ready = job_ready;
      w_res_valid = res_valid;
      w_res_data  = res_data;
      w_res_err   = res_err;
      w_awaddr    = M_AXI_AWADDR;
      w_awvalid   = M_AXI_AWVALID;
      w_wdata     = M_AXI_WDATA;
      w_wvalid    = M_AXI_WVALID;
      w_bready    = M_AXI_BREADY;
      w_araddr    = M_AXI_ARADDR;
      w_arvalid   = M_AXI_ARVALID;
      w_rready    = M_AXI_RREADY;

      case (r_state)
         IDLE: begin
            if (job_valid) begin
               w_a         = job_a;
               w_poll_cnt  = 16'd0;
               w_awaddr    = c_addr_x;
               w_wdata     = job_x;
               w_awvalid   = 1'b1;
               w_wvalid    = 1'b1;
               w_bready    = 1'b1;
               w_job_ready = 1'b0;
               w_res_err   = 2'b00;
               w_res_data  = '0;
               w_state     = WR_X;
            end
         end
         WR_X, WR_A, WR_START: begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) w_awvalid = 1'b0;
            if (M_AXI_WVALID && M_AXI_WREADY)   w_wvalid  = 1'b0;
            // The response is only meaningful once both address and data are accepted.
            if (!M_AXI_AWVALID && !M_AXI_WVALID && M_AXI_BVALID) begin
               if (M_AXI_BRESP != 2'b00) begin
                  w_bready    = 1'b0;
                  w_res_err   = 2'b01;
                  w_res_data  = '0;
                  w_res_valid = 1'b1;
                  w_state     = RESP;
               end else if (r_state == WR_X) begin
                  w_awaddr  = c_addr_a;
                  w_wdata   = r_a;
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_state   = WR_A;
               end else if (r_state == WR_A) begin
                  w_awaddr  = c_addr_start;
                  w_wdata   = 32'd1;
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
                  w_state   = WR_START;
               end else begin
                  w_bready  = 1'b0;
                  w_araddr  = c_addr_done;
                  w_arvalid = 1'b1;
                  w_state   = POLL_AR;
               end
            end
         end
         POLL_AR, RD_P_AR: begin
            if (M_AXI_ARREADY) begin
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
               w_state   = (r_state == POLL_AR) ? POLL_R : RD_P_R;
            end
         end
         POLL_R: begin
            if (M_AXI_RVALID) begin
               w_rready   = 1'b0;
               w_poll_cnt = r_poll_cnt + 16'd1;
               if (M_AXI_RRESP != 2'b00) begin
                  w_res_err   = 2'b01;
                  w_res_data  = '0;
                  w_res_valid = 1'b1;
                  w_state     = RESP;
               end else if (M_AXI_RDATA[0]) begin
                  w_araddr  = c_addr_p;
                  w_arvalid = 1'b1;
                  w_state   = RD_P_AR;
               end else if (w_poll_cnt == c_limit) begin
                  w_res_err   = 2'b10;
                  w_res_data  = '0;
                  w_res_valid = 1'b1;
                  w_state     = RESP;
               end else if (POLL_GAP == 0) begin
                  w_arvalid = 1'b1;
                  w_state   = POLL_AR;
               end else begin
                  w_gap_cnt = 16'd0;
                  w_state   = POLL_WAIT;
               end
            end
         end
         POLL_WAIT: begin
            if (r_gap_cnt == c_gap_last) begin
               w_arvalid = 1'b1;
               w_state   = POLL_AR;
            end else begin
               w_gap_cnt = r_gap_cnt + 16'd1;
            end
         end
         RD_P_R: begin
            if (M_AXI_RVALID) begin
               w_rready    = 1'b0;
               w_res_valid = 1'b1;
               w_state     = RESP;
               if (M_AXI_RRESP != 2'b00) begin
                  w_res_err  = 2'b01;
                  w_res_data = '0;
               end else begin
                  w_res_err  = 2'b00;
                  w_res_data = M_AXI_RDATA[RES_W-1:0];
               end
            end
         end
         RESP: begin
            if (res_ready) begin
               w_res_valid = 1'b0;
               w_job_ready = 1'b1;
               w_state     = IDLE;
            end
         end
         default: w_state = IDLE;
      endcase
   end

   always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
      if (M_AXI_ARESET) begin
         r_state       <= IDLE;
         r_a           <= 32'd0;
         r_poll_cnt    <= 16'd0;
         r_gap_cnt     <= 16'd0;
         job_ready     <= 1'b1;
         res_valid     <= 1'b0;
         res_data      <= '0;
         res_err       <= 2'b00;
         busy          <= 1'b0;
         M_AXI_AWADDR  <= 32'd0;
         M_AXI_AWVALID <= 1'b0;
         M_AXI_WDATA   <= 32'd0;
         M_AXI_WVALID  <= 1'b0;
         M_AXI_BREADY  <= 1'b0;
         M_AXI_ARADDR  <= 32'd0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_RREADY  <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_a           <= w_a;
         r_poll_cnt    <= w_poll_cnt;
         r_gap_cnt     <= w_gap_cnt;
         job_ready     <= w_job_ready;
         res_valid     <= w_res_valid;
         res_data      <= w_res_data;
         res_err       <= w_res_err;
         busy          <= (w_state != IDLE);
         M_AXI_AWADDR  <= w_awaddr;
         M_AXI_AWVALID <= w_awvalid;
         M_AXI_WDATA   <= w_wdata;
         M_AXI_WVALID  <= w_wvalid;
         M_AXI_BREADY  <= w_bready;
         M_AXI_ARADDR  <= w_araddr;
         M_AXI_ARVALID <= w_arvalid;
         M_AXI_RREADY  <= w_rready;
      end
   end

endmodule

`default_nettype wire
